// File: rtl/lu_issue_pkg.sv
// Shared logic-unit definitions: opcode encoding used by the decoder, the issue
// stage and the logic-unit datapath.
package lu_issue_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND  = 3'b000,
    LU_XOR  = 3'b001,
    LU_NAND = 3'b010,
    LU_OR   = 3'b011,
    LU_NOT  = 3'b100,
    LU_NOR  = 3'b101,
    LU_NEG  = 3'b110,
    LU_XNOR = 3'b111
  } lu_op_e;

endpackage

// File: rtl/lu_issue_regfile.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, synchronous clear to zero.
module lu_regfile #(
  parameter int N    = 32,
  parameter int REGS = 8,
  parameter int AW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [N-1:0]  rdata_a,
  output logic [N-1:0]  rdata_b,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd
);

  logic [N-1:0] mem [REGS];

  assign rdata_a = mem[ra];
  assign rdata_b = mem[rb];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

endmodule

// File: rtl/lu_issue.sv
// Issue/writeback stage for the logic unit: operand read with forwarding from EX,
// one EX cycle on lu_*, regfile write at the EX->WB transfer, result stream out.
module lu_issue
  import lu_issue_pkg::*;
#(
  parameter int N    = 32,
  parameter int REGS = 8,
  parameter int AW   = $clog2(REGS)
) (
  input  logic               clk,
  input  logic               rst,
  // Streams: a beat transfers on the rising edge where valid && ready; an
  // offered beat keeps its payload until taken; ready never waits on valid.
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LU_OP_W-1:0] in_op,
  input  logic [AW-1:0]      in_ra,
  input  logic [AW-1:0]      in_rb,
  input  logic [AW-1:0]      in_rd,
  output logic [N-1:0]       lu_a,
  output logic [N-1:0]       lu_b,
  output logic [LU_OP_W-1:0] lu_s,
  input  logic [N-1:0]       lu_c,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [AW-1:0]      res_rd,
  output logic [N-1:0]       res_data,
  output logic [15:0]        ret_count
);

  logic               ex_valid;
  logic [LU_OP_W-1:0] ex_op;
  logic [AW-1:0]      ex_rd;
  logic [N-1:0]       ex_a, ex_b;
  logic               wb_valid;
  logic [AW-1:0]      wb_rd;
  logic [N-1:0]       wb_data;

  logic               advance;
  logic [N-1:0]       rf_a, rf_b, op_a, op_b;

  assign advance  = !wb_valid || res_ready;
  assign in_ready = advance;

  // The EX result is not in the regfile until the next edge, so take it from lu_c.
  assign op_a = (ex_valid && (in_ra == ex_rd)) ? lu_c : rf_a;
  assign op_b = (ex_valid && (in_rb == ex_rd)) ? lu_c : rf_b;

  lu_regfile #(.N(N), .REGS(REGS), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra      (in_ra),
    .rb      (in_rb),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .we      (advance && ex_valid),
    .wa      (ex_rd),
    .wd      (lu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_op    <= LU_AND;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (advance) begin
      ex_valid <= in_valid;
      if (in_valid) begin
        ex_op <= in_op;
        ex_rd <= in_rd;
        ex_a  <= op_a;
        ex_b  <= op_b;
      end
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_rd   <= ex_rd;
        wb_data <= lu_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_count <= '0;
    end else if (wb_valid && res_ready) begin
      ret_count <= ret_count + 16'd1;
    end
  end

  assign lu_a      = ex_a;
  assign lu_b      = ex_b;
  assign lu_s      = ex_op;
  assign res_valid = wb_valid;
  assign res_rd    = wb_rd;
  assign res_data  = wb_data;

endmodule

// File: tb/tb_lu_issue.sv
// Bench for lu_issue: logic-unit model on lu_*, program-order architectural model
// feeding an expected-result queue, per-cycle compare, directed and random stimulus.
module tb_lu_issue;
  import lu_issue_pkg::*;

  localparam int N    = 32;
  localparam int REGS = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'b000;
  logic [AW-1:0] in_ra = '0, in_rb = '0, in_rd = '0;
  logic [N-1:0]  lu_a, lu_b, lu_c;
  logic [2:0]    lu_s;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [AW-1:0] res_rd;
  logic [N-1:0]  res_data;
  logic [15:0]   ret_count;

  int checks = 0;
  int fails  = 0;

  // Preload support: the logic-unit model returns force_val while force_en is set,
  // and the reference model takes pre_val as the result of the next accepted op.
  logic          force_en = 1'b0;
  logic [N-1:0]  force_val = '0;
  logic          pre_en = 1'b0;
  logic [N-1:0]  pre_val = '0;

  logic [N-1:0]      model_rf [REGS];
  logic [AW+N-1:0]   exp_q [$];
  int                exp_cnt = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  lu_issue #(.N(N), .REGS(REGS), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_rd     (in_rd),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_s      (lu_s),
    .lu_c      (lu_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_rd    (res_rd),
    .res_data  (res_data),
    .ret_count (ret_count)
  );

  function automatic logic [N-1:0] lu_fn(input logic [2:0] s, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    case (s)
      3'b000:  return a & b;
      3'b001:  return a ^ b;
      3'b010:  return ~(a & b);
      3'b011:  return a | b;
      3'b100:  return ~a;
      3'b101:  return ~(a | b);
      3'b110:  return (~a) + 32'd1;
      default: return ~(a ^ b);
    endcase
  endfunction

  always_comb begin
    lu_c = lu_fn(lu_s, lu_a, lu_b);
    if (force_en) lu_c = force_val;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_rd;
  logic [N-1:0]  prev_data, prev_a, prev_b;
  logic [2:0]    prev_s;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) model_rf[i] = '0;
      exp_q.delete();
      exp_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      logic [AW+N-1:0] e;
      logic [N-1:0]    r;
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!res_valid || res_ready)});
      chk("ret_count", {48'd0, ret_count}, {48'd0, exp_cnt[15:0]});
      if (prev_stall) begin
        chk("stall_res_rd", {61'd0, res_rd}, {61'd0, prev_rd});
        chk("stall_res_data", {32'd0, res_data}, {32'd0, prev_data});
        chk("stall_lu", {lu_s, lu_a, lu_b}, {prev_s, prev_a, prev_b});
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result actual=%0d/%h expected=none", res_rd, res_data);
        end else begin
          e = exp_q.pop_front();
          chk("result", {29'd0, res_rd, res_data}, {29'd0, e});
        end
        exp_cnt++;
      end
      if (in_valid && in_ready) begin
        r = pre_en ? pre_val : lu_fn(in_op, model_rf[in_ra], model_rf[in_rb]);
        model_rf[in_rd] = r;
        exp_q.push_back({in_rd, r});
      end
      prev_stall = res_valid && !res_ready;
      prev_rd = res_rd; prev_data = res_data;
      prev_a = lu_a; prev_b = lu_b; prev_s = lu_s;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Returns 1ns after the accepting edge, i.e. while the op sits in EX.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb, input logic [AW-1:0] rd);
    int n = 0;
    bit done = 0;
    in_valid = 1'b1; in_op = op; in_ra = ra; in_rb = rb; in_rd = rd;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else if (++n > 200) begin
        checks++;
        fails++;
        $display("FAIL issue_timeout actual=blocked expected=accept within 200 cycles");
        done = 1;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] rd, input logic [N-1:0] val);
    pre_en = 1'b1; pre_val = val;
    issue(LU_OR, '0, '0, rd);
    force_val = val; force_en = 1'b1;
    @(posedge clk);
    #1 force_en = 1'b0; pre_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  bit rand_phase;

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_res_valid", {63'd0, res_valid}, 64'd0);
    chk("reset_lu", {29'd0, lu_s, lu_a | lu_b}, 64'd0);
    chk("reset_lu_a", {32'd0, lu_a}, 64'd0);
    chk("reset_ret_count", {48'd0, ret_count}, 64'd0);

    // Independent ops on preloaded registers.
    @(posedge clk); #1;
    preload(3'd1, 32'hF0F0F0F0);
    preload(3'd2, 32'h0FF00FF0);
    issue(LU_AND, 3'd1, 3'd2, 3'd3);
    chk("and_lu_a", {32'd0, lu_a}, 64'hF0F0F0F0);
    chk("and_lu_b", {32'd0, lu_b}, 64'h0FF00FF0);
    chk("and_lu_s", {61'd0, lu_s}, 64'd0);
    @(posedge clk); #1;
    chk("and_res_valid", {63'd0, res_valid}, 64'd1);
    chk("and_res_rd", {61'd0, res_rd}, 64'd3);
    chk("and_res_data", {32'd0, res_data}, 64'h00F000F0);
    issue(LU_NEG, 3'd1, 3'd0, 3'd4);
    @(posedge clk); #1;
    chk("neg_res", {29'd0, res_rd, res_data}, {29'd0, 3'd4, 32'h0F0F0F10});

    // Back-to-back dependency through forwarding, no bubble.
    issue(LU_XOR, 3'd1, 3'd2, 3'd5);
    issue(LU_OR, 3'd5, 3'd5, 3'd6);
    chk("fwd_lu_a", {32'd0, lu_a}, 64'hFF00FF00);
    chk("fwd_lu_b", {32'd0, lu_b}, 64'hFF00FF00);
    chk("fwd_prev_rd", {61'd0, res_rd}, 64'd5);
    @(posedge clk); #1;
    chk("fwd_res", {29'd0, res_rd, res_data}, {29'd0, 3'd6, 32'hFF00FF00});

    // Backpressure with an instruction offered.
    res_ready = 1'b0;
    fork
      issue(LU_OR, 3'd1, 3'd2, 3'd7);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
          chk("bp_res", {29'd0, res_rd, res_data}, {29'd0, 3'd6, 32'hFF00FF00});
        end
        @(posedge clk); #1 res_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset while an op to r7 is in EX.
    issue(LU_OR, 3'd1, 3'd2, 3'd7);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_mid_ret_count", {48'd0, ret_count}, 64'd0);
    @(posedge clk); #1;
    issue(LU_OR, 3'd7, 3'd7, 3'd0);
    @(posedge clk); #1;
    chk("rst_mid_r7", {29'd0, res_rd, res_data}, 64'd0);

    // Random traffic with random backpressure.
    for (int i = 0; i < REGS; i++) preload(i[AW-1:0], $urandom);
    rand_phase = 1;
    fork
      begin
        while (rand_phase) begin
          @(posedge clk); #1;
          if (rand_phase) res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          issue($urandom_range(0, 7), $urandom_range(0, REGS-1),
                $urandom_range(0, REGS-1), $urandom_range(0, REGS-1));
        end
        rand_phase = 0;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("drain_random", 64'(exp_q.size()), 64'd0);

    // Counter wrap: 65537 retirements from a fresh reset.
    do_reset();
    in_valid = 1'b1;
    repeat (65537) begin
      in_op = $urandom_range(0, 7);
      in_ra = $urandom_range(0, REGS-1);
      in_rb = $urandom_range(0, REGS-1);
      in_rd = $urandom_range(0, REGS-1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_ret_count", {48'd0, ret_count}, 64'd1);
    chk("drain_wrap", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/lu_issue.md
# lu_issue

Issue and writeback stage that drives the logic unit's operand/opcode interface from a small architectural register file. Accepts register-addressed logic instructions over a valid/ready stream, reads and forwards operands, presents them to the combinational logic unit for one EX cycle, writes the result back, and reports each retired result on an output stream. It sits between the VLIW slot decoder and the logic-unit datapath slot.

## Interface
- N, 32, data width; must match the logic unit width
- REGS, 8, register-file depth; power of two, ≥ 2
- AW, $clog2(REGS), register address width
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_op  in  3  logic opcode; passed unchanged to lu_s
- in_ra, in_rb, in_rd  in  AW each  source A, source B, destination register
- lu_a, lu_b  out  N  operands to logic unit
- lu_s  out  3  opcode to logic unit
- lu_c  in  N  combinational result from logic unit
- res_valid  out  1  retired result available
- res_ready  in  1  consumer accepts result
- res_rd  out  AW  destination of retired result
- res_data  out  N  retired result value
- ret_count  out  16  count of retired results; wraps modulo 2^16

## Operation
- Two registered stages: EX (ex_valid, ex_op, ex_rd, ex_a, ex_b) and WB (wb_valid, wb_rd, wb_data).
- lu_a = ex_a, lu_b = ex_b, lu_s = ex_op; driven directly from EX registers. When EX is empty they hold their last value.
- advance = !wb_valid || res_ready. in_ready = advance.
- On advance, the following happen at the same edge:
  - EX loads the incoming instruction (ex_valid = in_valid).
  - WB loads the current EX contents (wb_valid = ex_valid, wb_data = lu_c).
  - If ex_valid, regfile[ex_rd] = lu_c.
- If advance is low, EX and WB hold, lu_* stay stable, and the regfile is not written.
- Operand read is combinational from the regfile with forwarding:
  - If ex_valid and the source address equals ex_rd, the operand is lu_c.
  - Otherwise the operand is the regfile value.
- No other hazard exists, because the regfile is written at the EX→WB transfer.
- Register 0 is an ordinary register; there is no hardwired zero.
- Unary opcodes (100, 110) still read in_rb; the logic unit ignores it.
- res_valid = wb_valid, res_rd = wb_rd, res_data = wb_data.
- ret_count increments on each res_valid && res_ready.

## Timing
- Reset, as a synchronous edge with rst=1:
  - all regfile entries = 0, ex_valid = wb_valid = 0, ex_a = ex_b = 0, ex_op = 000, ex_rd = wb_rd = 0, wb_data = 0, ret_count = 0.
  - Hence in_ready = 1, res_valid = 0, lu_a = lu_b = 0, lu_s = 000 from the first cycle after reset.
- rst overrides any in-flight handshake; instructions in EX/WB are discarded without regfile write.
- Latency, with no backpressure:
  - Instruction accepted at edge T is driven on lu_* during cycle T..T+1.
  - Its result is written to the regfile and res_valid is high after edge T+1.
  - A dependent instruction accepted at T+1 gets the value via forwarding. Throughput is one per cycle.
- Backpressure: when res_valid && !res_ready, in_ready drops in the same cycle (combinational). The pipeline resumes on the cycle res_ready rises.
- res_* must remain stable while res_valid && !res_ready.
- Simultaneous events:
  - Same-edge EX writeback and a regfile read of that address: the forwarded lu_c is used.
  - in_ra == in_rb == ex_rd: both operands are forwarded.
- ret_count wraps from 16'hFFFF to 0.

## Structure
- Shared package: LU opcode constants (LU_AND=000, LU_XOR=001, LU_NAND=010, LU_OR=011, LU_NOT=100, LU_NOR=101, LU_NEG=110, LU_XNOR=111), reused by the decoder and the logic unit.
- One sub-module: lu_regfile, with REGS×N storage, two combinational read ports, one synchronous write port, and synchronous reset to zero.
- The forwarding mux and the stage registers live in lu_issue.
- The logic unit is external, connected through lu_a/lu_b/lu_s/lu_c. The bench pairs the block with a logic-unit model.

## Test plan
- Reset then idle: after rst for 2 cycles, expect in_ready=1, res_valid=0, lu_a=lu_b=0, lu_s=000, ret_count=0.
- Independent ops, regs preloaded via prior OR ops:
  - Given r1=0xF0F0F0F0 and r2=0x0FF00FF0, AND r3=r1,r2 gives res_data=0x00F000F0, res_rd=3, one cycle after accept.
  - NEG r4=r1 gives 0x0F0F0F10.
- Back-to-back dependency: XOR r5=r1,r2, then immediately OR r6=r5,r5. Expect r6 = 0xFF00FF00 (forwarded), with no bubble.
- Backpressure: hold res_ready=0 for 3 cycles with instructions offered.
  - Expect in_ready=0, lu_* stable, and res_data unchanged.
  - After release, results emerge in order with none lost or duplicated.
- Reset mid-operation: assert rst while an op to r7 is in EX. Expect r7=0, res_valid=0 and ret_count=0 after the edge.
- Counter wrap: retire 65537 ops. Expect ret_count=1.
